// File: rtl/win_check_scheduler.sv
// -----------------------------------------------------------------------------
// win_check_scheduler
//
// Purpose
//   After a piece is dropped at (row, col) on a ROWS x COLS connect-four board,
//   walk the 13 candidate four-in-a-row directions in order. A direction is
//   launched on an external direction checker only if all four of its cells
//   lie on the board. The first nonzero checker result is kept as the winner.
//
//   Direction codes (chk_direction):
//     1        DOWN                 (dr,dc) = (-k, 0),  k = 1..3
//     2..5     ROW_1..ROW_4         dr = 0, dc spans -3..-1 / -2..+1 / -1..+2 / +1..+3
//     6..9     DIAG_RIGHT_UP_1..4   dr = dc, same spans as ROW_n
//     10..13   DIAG_LEFT_DOWN_1..4  dr as DIAG_RIGHT_UP_n, dc = -dr
//
// Configuration
//   WIN_CHECK_EARLY_EXIT_EN  When defined, a nonzero checker result ends the
//                            sequence immediately. When undefined, every
//                            in-bounds direction is launched.
//
// Parameters
//   ROWS  board rows, 4..8 (row 0 is the bottom row)
//   COLS  board columns, 4..8 (column 0 is the leftmost column)
//
// Ports
//   clk            in   sole clock, rising edge
//   rst            in   asynchronous, active-high reset
//   start          in   one-cycle request; accepted only while idle
//   row, col       in   [2:0] coordinates of the dropped piece
//   busy           out  high while a check sequence runs
//   done           out  one-cycle completion pulse
//   winner         out  [1:0] 00 = none, else player code; held until next start
//   chk_start      out  one-cycle launch pulse to the direction checker
//   chk_row        out  [2:0] latched row driven to the checker
//   chk_col        out  [2:0] latched column driven to the checker
//   chk_direction  out  [3:0] direction code 1..13, 0 when idle
//   chk_finished   in   checker completion pulse
//   chk_winner     in   [1:0] checker result, valid with chk_finished
// -----------------------------------------------------------------------------
module win_check_scheduler #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] row,
  input  logic [2:0] col,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic       chk_start,
  output logic [2:0] chk_row,
  output logic [2:0] chk_col,
  output logic [3:0] chk_direction,
  input  logic       chk_finished,
  input  logic [1:0] chk_winner
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [3:0]        FIRST_DIR = 4'd1;
  localparam logic [3:0]        LAST_DIR  = 4'd13;
  // Board limits in the same signed width as the offset arithmetic.
  localparam logic signed [5:0] ROW_MAX   = 6'(ROWS - 1);
  localparam logic signed [5:0] COL_MAX   = 6'(COLS - 1);

  state_e     state_q, state_d;
  logic [3:0] dir_q, dir_d;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic [1:0] winner_q, winner_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       chk_start_q, chk_start_d;
  logic [3:0] chk_dir_q, chk_dir_d;

  // ---------------------------------------------------------------------------
  // Offset span of the current direction. Only the extremes matter: the four
  // checked cells lie on a straight line, so the whole set is on the board
  // exactly when both ends are.
  // ---------------------------------------------------------------------------
  logic signed [5:0] dr_lo, dr_hi, dc_lo, dc_hi;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned (which would infer a latch).
    dr_lo = 6'sd0;
    dr_hi = 6'sd0;
    dc_lo = 6'sd0;
    dc_hi = 6'sd0;
    case (dir_q)
      4'd1:  begin dr_lo = -6'sd3; dr_hi = -6'sd1;                                   end
      4'd2:  begin                                   dc_lo = -6'sd3; dc_hi = -6'sd1; end
      4'd3:  begin                                   dc_lo = -6'sd2; dc_hi =  6'sd1; end
      4'd4:  begin                                   dc_lo = -6'sd1; dc_hi =  6'sd2; end
      4'd5:  begin                                   dc_lo =  6'sd1; dc_hi =  6'sd3; end
      4'd6:  begin dr_lo = -6'sd3; dr_hi = -6'sd1; dc_lo = -6'sd3; dc_hi = -6'sd1; end
      4'd7:  begin dr_lo = -6'sd2; dr_hi =  6'sd1; dc_lo = -6'sd2; dc_hi =  6'sd1; end
      4'd8:  begin dr_lo = -6'sd1; dr_hi =  6'sd2; dc_lo = -6'sd1; dc_hi =  6'sd2; end
      4'd9:  begin dr_lo =  6'sd1; dr_hi =  6'sd3; dc_lo =  6'sd1; dc_hi =  6'sd3; end
      // Left-down diagonals mirror the column span of the right-up ones.
      4'd10: begin dr_lo = -6'sd3; dr_hi = -6'sd1; dc_lo =  6'sd1; dc_hi =  6'sd3; end
      4'd11: begin dr_lo = -6'sd2; dr_hi =  6'sd1; dc_lo = -6'sd1; dc_hi =  6'sd2; end
      4'd12: begin dr_lo = -6'sd1; dr_hi =  6'sd2; dc_lo = -6'sd2; dc_hi =  6'sd1; end
      4'd13: begin dr_lo =  6'sd1; dr_hi =  6'sd3; dc_lo = -6'sd3; dc_hi = -6'sd1; end
      default: ;
    endcase
  end

  // Coordinates are widened to signed 6 bits so that e.g. 0-3 goes negative
  // and 6+3 does not wrap back onto the board.
  logic signed [5:0] r_lo, r_hi, c_lo, c_hi;
  logic              in_bounds;

  always_comb begin
    r_lo      = $signed({3'b000, row_q}) + dr_lo;
    r_hi      = $signed({3'b000, row_q}) + dr_hi;
    c_lo      = $signed({3'b000, col_q}) + dc_lo;
    c_hi      = $signed({3'b000, col_q}) + dc_hi;
    in_bounds = (r_lo >= 6'sd0) && (r_hi <= ROW_MAX) &&
                (c_lo >= 6'sd0) && (c_hi <= COL_MAX);
  end

  // A nonzero checker result may end the sequence early.
  logic early_stop;

`ifdef WIN_CHECK_EARLY_EXIT_EN
  assign early_stop = (chk_winner != 2'b00);
`else
  assign early_stop = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic. Output registers are loaded from the next state so that
  // every output is a flop and lines up with the state it belongs to.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    row_d    = row_q;
    col_d    = col_q;
    winner_d = winner_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d    = row;
          col_d    = col;
          winner_d = 2'b00;
          dir_d    = FIRST_DIR;
          state_d  = S_SELECT;
        end
      end

      S_SELECT: begin
        if (in_bounds) begin
          state_d = S_LAUNCH;
        end else if (dir_q == LAST_DIR) begin
          state_d = S_DONE;
        end else begin
          dir_d = dir_q + 4'd1;
        end
      end

      S_LAUNCH: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (chk_finished) begin
          // Keep the first nonzero result only.
          if ((winner_q == 2'b00) && (chk_winner != 2'b00)) begin
            winner_d = chk_winner;
          end
          if (early_stop || (dir_q == LAST_DIR)) begin
            state_d = S_DONE;
          end else begin
            dir_d   = dir_q + 4'd1;
            state_d = S_SELECT;
          end
        end
      end

      S_DONE: begin
        dir_d   = FIRST_DIR;
        state_d = S_IDLE;
      end

      default: begin
        dir_d   = FIRST_DIR;
        state_d = S_IDLE;
      end
    endcase

    busy_d      = (state_d == S_SELECT) || (state_d == S_LAUNCH) || (state_d == S_WAIT);
    done_d      = (state_d == S_DONE);
    chk_start_d = (state_d == S_LAUNCH);
    chk_dir_d   = ((state_d == S_LAUNCH) || (state_d == S_WAIT)) ? dir_d : 4'd0;
  end

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dir_q       <= FIRST_DIR;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      winner_q    <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      chk_start_q <= 1'b0;
      chk_dir_q   <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      dir_q       <= dir_d;
      row_q       <= row_d;
      col_q       <= col_d;
      winner_q    <= winner_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      chk_start_q <= chk_start_d;
      chk_dir_q   <= chk_dir_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign winner        = winner_q;
  assign chk_start     = chk_start_q;
  assign chk_row       = row_q;
  assign chk_col       = col_q;
  assign chk_direction = chk_dir_q;

endmodule

// File: tb/tb_win_check_scheduler.sv
// -----------------------------------------------------------------------------
// tb_win_check_scheduler
//
// Directed bench for win_check_scheduler on a 6x7 board. A behavioural
// direction checker answers each launch six cycles later with a result taken
// from a per-direction table; it also logs every launch and counts done
// pulses. Expected launch lists and cycle counts are worked out by hand.
// -----------------------------------------------------------------------------
module tb_win_check_scheduler;

  localparam int ROWS = 6;
  localparam int COLS = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] row;
  logic [2:0] col;
  logic       busy;
  logic       done;
  logic [1:0] winner;
  logic       chk_start;
  logic [2:0] chk_row;
  logic [2:0] chk_col;
  logic [3:0] chk_direction;
  logic       chk_finished;
  logic [1:0] chk_winner;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  win_check_scheduler #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .row           (row),
    .col           (col),
    .busy          (busy),
    .done          (done),
    .winner        (winner),
    .chk_start     (chk_start),
    .chk_row       (chk_row),
    .chk_col       (chk_col),
    .chk_direction (chk_direction),
    .chk_finished  (chk_finished),
    .chk_winner    (chk_winner)
  );

  // ---------------------------------------------------------------------------
  // Checker model: acts 1 ns after each rising edge.
  // ---------------------------------------------------------------------------
  logic [1:0] win_map [0:15];
  int         n_done  = 0;
  int         inj_cnt = 0;
  int         inj_seen = 0;
  int         log_dir[$];
  int         log_row[$];
  int         log_col[$];

  initial begin
    int         cnt;
    logic [3:0] pend_dir;
    cnt          = 0;
    pend_dir     = 4'd0;
    chk_finished = 1'b0;
    chk_winner   = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      chk_finished = 1'b0;
      chk_winner   = 2'b11;  // junk outside the finished cycle
      if (done) n_done++;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            chk_finished = 1'b1;
            chk_winner   = win_map[pend_dir];
          end
        end
        if (chk_start) begin
          cnt      = 6;
          pend_dir = chk_direction;
          log_dir.push_back(int'(chk_direction));
          log_row.push_back(int'(chk_row));
          log_col.push_back(int'(chk_col));
        end
      end
      if (inj_cnt != inj_seen) begin
        inj_seen     = inj_cnt;
        chk_finished = 1'b1;
        chk_winner   = 2'b01;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one sequence from idle. Optionally issues a second start while the
  // first launch is in WAIT, and/or a start during the DONE cycle.
  task automatic run_seq(input string tag, input logic [2:0] r, input logic [2:0] c,
                         input bit mid_start, input bit done_start,
                         output int cyc, output int base, output int done_base);
    bit mid_sent;
    mid_sent  = 1'b0;
    base      = log_dir.size();
    done_base = n_done;
    row   = r;
    col   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    check({tag, "_busy_c1"}, 32'(busy), 32'd1);
    check({tag, "_winner_cleared"}, 32'(winner), 32'd0);
    while (!done && cyc < 300) begin
      if (mid_start && !mid_sent && chk_direction != 4'd0 && !chk_start) begin
        start    = 1'b1;
        row      = 3'd0;
        col      = 3'd0;
        mid_sent = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_dir_in_done"}, 32'(chk_direction), 32'd0);
    if (done_start) begin
      start = 1'b1;
      row   = 3'd1;
      col   = 3'd1;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_n_done"}, 32'(n_done - done_base), 32'd1);
  endtask

  task automatic check_launches(input string tag, input int base, input int exp[$],
                                input int r, input int c);
    check({tag, "_n_launch"}, 32'(log_dir.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size() && base + i < log_dir.size(); i++) begin
      check($sformatf("%s_dir%0d", tag, i), 32'(log_dir[base+i]), 32'(exp[i]));
      check($sformatf("%s_row%0d", tag, i), 32'(log_row[base+i]), 32'(r));
      check($sformatf("%s_col%0d", tag, i), 32'(log_col[base+i]), 32'(c));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cyc, base, dbase, snap_launch, snap_done, wcyc;
    int exp_a[$];
    int exp_b[$];
    int exp_c[$];
    int exp_d[$];
    exp_a = '{5, 9};
    exp_b = '{1, 2, 6};
    exp_c = '{1, 2, 3, 4, 5, 6, 7, 8, 10, 11, 12};
`ifdef WIN_CHECK_EARLY_EXIT_EN
    exp_d = '{1, 2, 3};
`else
    exp_d = '{1, 2, 3, 4, 5, 6, 7, 8, 10, 11, 12};
`endif
    for (int i = 0; i < 16; i++) win_map[i] = 2'b00;

    rst   = 1'b1;
    start = 1'b0;
    row   = 3'd0;
    col   = 3'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",    32'(busy),          32'd0);
    check("rst_done",    32'(done),          32'd0);
    check("rst_winner",  32'(winner),        32'd0);
    check("rst_start",   32'(chk_start),     32'd0);
    check("rst_dir",     32'(chk_direction), 32'd0);
    check("rst_row",     32'(chk_row),       32'd0);
    check("rst_col",     32'(chk_col),       32'd0);
    rst = 1'b0;
    @(negedge clk);

    // A: corner (0,0) -> ROW_4, DIAG_RIGHT_UP_4; start in DONE ignored.
    // Latency 1 + 13 + 2*(1+6) = 28.
    run_seq("A", 3'd0, 3'd0, 1'b0, 1'b1, cyc, base, dbase);
    check("A_latency", 32'(cyc), 32'd28);
    check_launches("A", base, exp_a, 0, 0);
    check("A_winner", 32'(winner), 32'd0);

    // B: top-right corner (5,6) -> DOWN, ROW_1, DIAG_RIGHT_UP_1. 1+13+3*7 = 35.
    run_seq("B", 3'd5, 3'd6, 1'b0, 1'b1, cyc, base, dbase);
    check("B_latency", 32'(cyc), 32'd35);
    check_launches("B", base, exp_b, 5, 6);

    // C: centre (3,3) -> 11 launches, 9 and 13 skipped. 1+13+11*7 = 91.
    run_seq("C", 3'd3, 3'd3, 1'b0, 1'b0, cyc, base, dbase);
    check("C_latency", 32'(cyc), 32'd91);
    check_launches("C", base, exp_c, 3, 3);
    check("C_winner", 32'(winner), 32'd0);

    // D: checker reports 10 on ROW_2 and 01 later on DIAG_RIGHT_UP_2.
    win_map[3] = 2'b10;
    win_map[7] = 2'b01;
    run_seq("D", 3'd3, 3'd3, 1'b0, 1'b0, cyc, base, dbase);
`ifdef WIN_CHECK_EARLY_EXIT_EN
    check("D_latency", 32'(cyc), 32'd25);
`else
    check("D_latency", 32'(cyc), 32'd91);
`endif
    check_launches("D", base, exp_d, 3, 3);
    check("D_winner", 32'(winner), 32'd2);
    repeat (4) @(negedge clk);
    check("D_winner_held", 32'(winner), 32'd2);
    win_map[3] = 2'b00;
    win_map[7] = 2'b00;

    // E: second start (0,0) during WAIT of a (3,3) run is ignored.
    run_seq("E", 3'd3, 3'd3, 1'b1, 1'b0, cyc, base, dbase);
    check("E_latency", 32'(cyc), 32'd91);
    check_launches("E", base, exp_c, 3, 3);
    check("E_row_kept", 32'(chk_row), 32'd3);
    check("E_col_kept", 32'(chk_col), 32'd3);

    // F: reset during WAIT, then a late chk_finished with 01.
    row   = 3'd3;
    col   = 3'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wcyc  = 0;
    while (!(chk_direction != 4'd0 && !chk_start) && wcyc < 50) begin
      @(negedge clk);
      wcyc++;
    end
    check("F_reached_wait", 32'(chk_direction), 32'd1);
    snap_done = n_done;
    rst = 1'b1;
    #1;
    check("F_async_busy", 32'(busy),          32'd0);
    check("F_async_dir",  32'(chk_direction), 32'd0);
    check("F_async_row",  32'(chk_row),       32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    snap_launch = log_dir.size();
    inj_cnt++;
    repeat (20) @(negedge clk);
    check("F_no_done",    32'(n_done - snap_done),          32'd0);
    check("F_winner",     32'(winner),                      32'd0);
    check("F_busy",       32'(busy),                        32'd0);
    check("F_done",       32'(done),                        32'd0);
    check("F_start",      32'(chk_start),                   32'd0);
    check("F_dir",        32'(chk_direction),               32'd0);
    check("F_col",        32'(chk_col),                     32'd0);
    check("F_no_launch",  32'(log_dir.size() - snap_launch), 32'd0);

    // G: recovery after reset, direction index restarts at 1.
    run_seq("G", 3'd0, 3'd0, 1'b0, 1'b0, cyc, base, dbase);
    check("G_latency", 32'(cyc), 32'd28);
    check_launches("G", base, exp_a, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/win_check_scheduler.md
WIN_CHECK_SCHEDULER -- requirements
Module: win_check_scheduler

Interface
REQ-001 Parameter ROWS, default 6: board row count, 4..8; row 0 is the bottom row.
REQ-002 Parameter COLS, default 7: board column count, 4..8; column 0 is the leftmost column.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to check the piece just dropped at row/col.
REQ-006 row  input  3  row of the dropped piece; sampled only on an accepted start.
REQ-007 col  input  3  column of the dropped piece; sampled only on an accepted start.
REQ-008 busy  output  1  high while a check sequence runs.
REQ-009 done  output  1  one-cycle pulse when the sequence completes.
REQ-010 winner  output  2  result code (00 none, else player code); valid from done, held until the next accepted start.
REQ-011 chk_start  output  1  one-cycle launch pulse to the direction checker.
REQ-012 chk_row, chk_col  output  3 each  latched coordinates driven to the checker.
REQ-013 chk_direction  output  4  direction code 1..13 (DOWN, ROW_1..4, DIAG_RIGHT_UP_1..4, DIAG_LEFT_DOWN_1..4); 0 when idle.
REQ-014 chk_finished  input  1  checker completion pulse.
REQ-015 chk_winner  input  2  checker result; valid only in the cycle chk_finished=1.

Function
REQ-016 FSM states SHALL be IDLE, SELECT, LAUNCH, WAIT, DONE; all outputs registered.
REQ-017 IDLE: start=1 latches row/col, clears winner, sets direction index d=1, and goes to SELECT; busy=1 from the next cycle.
REQ-018 start while not in IDLE SHALL be ignored, with no effect on the latched coordinates, d or winner.
REQ-019 SELECT (1 cycle per direction) SHALL evaluate whether direction d is in bounds. Direction d is in bounds only if all four cells it checks satisfy 0<=r<=ROWS-1 and 0<=c<=COLS-1, computed without 3-bit wrap-around. If in bounds, go to LAUNCH; if not, skip it (d+1, stay in SELECT; after d=13 go to DONE).
REQ-020 Cell offsets (dr,dc) per direction, with k=1..3:
  DOWN (-k,0).
  ROW_1 dc -3..-1; ROW_2 -2..+1; ROW_3 -1..+2; ROW_4 +1..+3.
  DIAG_RIGHT_UP_n: dr=dc, spans as ROW_n.
  DIAG_LEFT_DOWN_n: dr as RIGHT_UP_n, dc=-dr.
REQ-021 LAUNCH SHALL drive chk_start=1 for exactly one cycle, with chk_direction=d and chk_row/chk_col stable, then go to WAIT.
REQ-022 WAIT SHALL hold until chk_finished=1 and sample chk_winner in that same cycle. If winner is still 00 and chk_winner!=00, latch chk_winner into winner. Then go to the next d (SELECT), or to DONE after d=13.
REQ-023 DONE (1 cycle): done=1, busy=0, chk_direction=0; then return to IDLE. A start arriving in the DONE cycle SHALL be ignored.
REQ-024 chk_finished outside WAIT SHALL be ignored.
REQ-025 Worst case is 13 launches; idle-to-done latency = 1 + 13 SELECT cycles + per launch (1 + checker latency).

Reset
REQ-026 rst SHALL asynchronously force IDLE, busy=0, done=0, winner=00, chk_start=0, chk_direction=0, chk_row=0, chk_col=0, d=1.
REQ-027 Reset during WAIT SHALL abandon the sequence with no done pulse; any later chk_finished pulse SHALL be ignored.

Configuration
REQ-028 With WIN_CHECK_EARLY_EXIT_EN defined, a nonzero chk_winner in WAIT SHALL go directly to DONE and no further directions are launched.
REQ-029 Without WIN_CHECK_EARLY_EXIT_EN, all in-bounds directions SHALL be launched and winner holds the first nonzero result.

Verification (ROWS=6, COLS=7; behavioural checker model with 6-cycle latency)
REQ-030 start, row=0, col=0 -> exactly 2 launches, directions 5 (ROW_4) then 9 (DIAG_RIGHT_UP_4); winner=00; one done pulse.
REQ-031 start, row=5, col=6 -> launches 1, 2, 6 only (DOWN, ROW_1, DIAG_RIGHT_UP_1).
REQ-032 start, row=3, col=3 -> 11 launches, with directions 9 and 13 skipped.
REQ-033 row=3, col=3, model returns 10 on direction 3 -> with EN: launches 1, 2, 3, then done, winner=10; without EN: 11 launches, winner=10.
REQ-034 second start during WAIT -> ignored; latched row/col unchanged; exactly one done pulse.
REQ-035 rst pulsed during WAIT, then a late chk_finished with winner=01 -> all outputs at reset values, no done pulse, winner=00.
